pe_stage_sequencer: RTL and testbench
=====================================

// Module: pe_stage_sequencer
// PURPOSE
//   Sequences one 4-input butterfly PE (3-cycle pipe: add/sub, twiddle multiply, output select) over a full in-place FFT.
//   Issues per-stage group read addresses, twiddle addresses and bypass_n, then writes results back after the PE latency.
//   Sits between the data/twiddle memories and the PE; start/done handshake to the top-level controller.
// PARAMETERS
//   N_LOG2      8  log2 FFT points; groups per stage G = 2**(N_LOG2-2); stages S = N_LOG2-1
//   RD_LATENCY  1  data and twiddle memory read latency, cycles (>=1)
//   AW          N_LOG2-2  group/twiddle address width (derived, do not override)
// PORTS
//   Clk       in   1   clock, rising edge
//   Reset_n   in   1   asynchronous active-low reset
//   start     in   1   begin transform; sampled only in IDLE
//   hold      in   1   suspend issue of new groups (in-flight groups still drain)
//   busy      out  1   high from start acceptance until done
//   done      out  1   one-cycle pulse after final write-back
//   stage     out  3   current stage index 0..S-1
//   rd_en     out  1   data memory read strobe
//   rd_addr   out  AW  group index g
//   tf_en     out  1   twiddle ROM read strobe
//   tf_addr   out  AW  twiddle index
//   bypass_n  out  1   to PE; 0 selects un-multiplied difference outputs
//   wr_en     out  1   write-back strobe (PE outputs valid)
//   wr_addr   out  AW  write-back group index
// BEHAVIOUR
//   - Reset (async): state IDLE; every output 0; g, stage and all delay-line entries cleared; in-flight writes discarded.
//   - FSM IDLE -> RUN on start. RUN -> DRAIN after issuing g=G-1. DRAIN -> RUN (stage+1) or -> DONE (last stage).
//     DONE -> IDLE after 1 cycle, with done=1.
//   - RUN: each cycle with hold=0: rd_en=1, rd_addr=g, g++. With hold=1: rd_en=0 and g holds. start is ignored.
//   - DRAIN waits exactly RD_LATENCY+3 cycles after the last issue, so the last write precedes the next stage's first
//     read (no RAW hazard); hold is ignored in DRAIN.
//   - Alignment relative to a rd_en issue at cycle t:
//     tf_en/tf_addr at t+1, with tf_addr = (g << stage) mod G.
//     bypass_n at t+RD_LATENCY+2, =0 when stage==S-1, else 1.
//     wr_en/wr_addr=g at t+RD_LATENCY+3.
//     Implement all of these as delay lines of {valid,g,stage}.
//   - Delay lines advance every cycle regardless of hold (the PE has no stall).
//   - busy=1 in RUN/DRAIN/DONE. stage resets to 0 on start. g wraps to 0 at stage change.
//   - Reset mid-operation aborts immediately; no done pulse.
// CONFIGURATION
//   PE_SEQ_PERF_EN defined:
//     - adds output cycle_count[31:0], cleared on start, +1 each busy cycle, frozen after done.
//     - adds output hold_count[31:0], counting RUN cycles with hold=1.
//   Macro undefined: neither port nor counter exists.
// STRUCTURE
//   Package pe_seq_pkg:
//     - state enum {IDLE, RUN, DRAIN, DONE}
//     - localparam PE_LATENCY = 3
//     - function twiddle_index(g, stage)
//   Sub-module pe_seq_delay #(W, DEPTH): resettable shift register carrying {valid,g,stage}; instantiated once.
//   bypass_n and wr_* taps come from it.
// TESTING (N_LOG2=4, RD_LATENCY=1: G=4, S=3)
//   1 start pulse, hold=0 -> rd_addr 0,1,2,3 per stage.
//     wr_addr 0..3 four cycles after each read.
//     Per stage 4 issue + 4 drain cycles; done at cycle 25 after start; busy high for cycles 1..25.
//   2 Same run -> tf_addr stage0: 0,1,2,3; stage1: 0,2,0,2; stage2: 0,0,0,0.
//     bypass_n=0 only on stage-2 output cycles.
//   3 hold=1 for 2 cycles after g=1 issued -> rd_en low 2 cycles; wr_en for g=0,1 still at +4.
//     Stage ends 2 cycles later; done at 27.
//   4 start reasserted while busy -> no effect; exactly one done pulse, stage sequence unchanged.
//   5 Reset_n low mid stage 1 -> all outputs 0 asynchronously, no wr_en or done afterwards.
//     A fresh start then runs cleanly from stage 0.
//   6 PE_SEQ_PERF_EN with scenario 3 -> cycle_count=27, hold_count=2 after done.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - shared types, constants and twiddle helper for the FFT stage sequencer
package pe_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Butterfly PE pipe depth: add/sub, twiddle multiply, output select.
    localparam int PE_LATENCY = 3;

    // Working width of the twiddle helper; callers slice the low aw bits.
    localparam int IDX_W = 16;

    // Twiddle index for group g in a given stage: (g << stage) mod 2**aw.
    function automatic logic [IDX_W-1:0] twiddle_index(
        input logic [IDX_W-1:0] g,
        input logic [2:0]       stage,
        input int               aw
    );
        logic [IDX_W-1:0] mask;
        mask = (IDX_W'(1) << aw) - IDX_W'(1);
        return (g << stage) & mask;
    endfunction

endpackage

// File: rtl/pe_seq_delay.sv
// rtl/pe_seq_delay.sv - resettable shift register carrying {valid,g,stage} alongside the PE pipe
//
// Ports:
//   Clk      clock, rising edge
//   Reset_n  asynchronous active-low reset, clears every entry
//   d        entry pushed in each cycle
//   taps     taps[k] is d delayed by k+1 cycles
module pe_seq_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [W-1:0]              d,
    output logic [DEPTH-1:0][W-1:0]   taps
);

    // Advances every cycle: the PE itself never stalls, so neither does its shadow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            taps <= '0;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/pe_stage_sequencer.sv
// rtl/pe_stage_sequencer.sv - sequences a 4-input butterfly PE over all stages of an in-place FFT
//
// Optional feature macro: PE_SEQ_PERF_EN (adds cycle_count / hold_count outputs).
//
// Ports:
//   Clk, Reset_n        clock (rising) and asynchronous active-low reset
//   start               begin transform, sampled only in IDLE
//   hold                suspend issue of new groups while in RUN
//   busy, done          busy from start acceptance until done; done is a one-cycle pulse
//   stage               current stage index
//   rd_en, rd_addr      data memory group read
//   tf_en, tf_addr      twiddle ROM read, one cycle after the data read
//   bypass_n            to PE, 0 selects un-multiplied outputs (last stage)
//   wr_en, wr_addr      write-back of PE results
//   cycle_count         (PE_SEQ_PERF_EN) busy cycles of the last transform
//   hold_count          (PE_SEQ_PERF_EN) RUN cycles spent with hold asserted
module pe_stage_sequencer
    import pe_seq_pkg::*;
#(
    parameter int N_LOG2     = 8,
    parameter int RD_LATENCY = 1,
    parameter int AW         = N_LOG2 - 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic [2:0]    stage,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          tf_en,
    output logic [AW-1:0] tf_addr,
    output logic          bypass_n,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [31:0]   cycle_count,
    output logic [31:0]   hold_count
`endif
);

    localparam int G       = 1 << AW;
    localparam int S       = N_LOG2 - 1;
    localparam int DEPTH   = RD_LATENCY + PE_LATENCY;
    localparam int DW      = 1 + AW + 3;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int BYP_TAP = RD_LATENCY + 1;
    localparam int WR_TAP  = DEPTH - 1;

    seq_state_t    state_q, state_d;
    logic [AW-1:0] g_q, g_d;
    logic [2:0]    stage_q, stage_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DEPTH-1:0][DW-1:0] taps;
    logic [DW-1:0]            line_in;
    logic [IDX_W-1:0]         tw;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    g_d     = '0;
                end
            end
            RUN: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    g_d   = g_q + AW'(1);
                    if (g_q == AW'(G - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                // Wait until the last issued group has been written back so the
                // next stage never reads a location still in flight.
                if (cnt_q == CW'(DEPTH - 1)) begin
                    cnt_d = '0;
                    g_d   = '0;
                    if (stage_q == 3'(S - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign stage   = stage_q;
    assign rd_addr = rd_en ? g_q : '0;

    assign line_in = {rd_en, g_q, stage_q};

    pe_seq_delay #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_delay (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       (line_in),
        .taps    (taps)
    );

    // Twiddle read follows the data read by one cycle so both arrive at the PE together.
    assign tf_en   = taps[0][DW-1];
    assign tw      = twiddle_index(IDX_W'(taps[0][3 +: AW]), taps[0][2:0], AW);
    assign tf_addr = tf_en ? tw[AW-1:0] : '0;

    assign bypass_n = taps[BYP_TAP][DW-1] & (taps[BYP_TAP][2:0] != 3'(S - 1));

    assign wr_en   = taps[WR_TAP][DW-1];
    assign wr_addr = wr_en ? taps[WR_TAP][3 +: AW] : '0;

    // Only a few fields of the delay line are tapped; fold the rest away.
    logic unused_bits;
    assign unused_bits = ^{taps, tw};

`ifdef PE_SEQ_PERF_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cycle_count <= '0;
            hold_count  <= '0;
        end else if (state_q == IDLE && start) begin
            cycle_count <= '0;
            hold_count  <= '0;
        end else begin
            // Stops counting once back in IDLE, which freezes the value after done.
            if (busy) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (state_q == RUN && hold) begin
                hold_count <= hold_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_stage_sequencer.sv
// tb/tb_pe_stage_sequencer.sv - scoreboard bench for pe_stage_sequencer (N_LOG2=4, RD_LATENCY=1)
module tb_pe_stage_sequencer;

    localparam int N_LOG2 = 4;
    localparam int RD_LAT = 1;
    localparam int AW     = 2;
    localparam int G      = 4;
    localparam int S      = 3;
    localparam int HP_N   = 128;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          busy, done, rd_en, tf_en, bypass_n, wr_en;
    logic [2:0]    stage;
    logic [AW-1:0] rd_addr, tf_addr, wr_addr;
`ifdef PE_SEQ_PERF_EN
    logic [31:0]   cycle_count, hold_count;
`endif

    pe_stage_sequencer #(
        .N_LOG2     (N_LOG2),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .tf_en    (tf_en),
        .tf_addr  (tf_addr),
        .bypass_n (bypass_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
`ifdef PE_SEQ_PERF_EN
        ,
        .cycle_count (cycle_count),
        .hold_count  (hold_count)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int stg;
    } ev_t;

    // Expected events per stream: 0 rd, 1 tf, 2 bypass, 3 wr, 4 done
    ev_t q[5][$];
    int  errors = 0;
    int  checks = 0;
    int  busy_lo = 1;
    int  busy_hi = 0;
    bit  mon_en = 1'b0;
    bit  hp[HP_N];

    function automatic void chk(input int k, input string nm, input logic v, input int addr, input int stg);
        ev_t e;
        while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
            e = q[k].pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing at cycle %0d: got no strobe, required addr=%0d", nm, e.cyc, e.addr);
        end
        if (v) begin
            checks++;
            if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
                errors++;
                $display("FAIL %s unexpected at cycle %0d: got strobe addr=%0d, required none", nm, cyc, addr);
            end else begin
                e = q[k].pop_front();
                if (addr != e.addr || stg != e.stg) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got addr=%0d stage=%0d, required addr=%0d stage=%0d",
                             nm, cyc, addr, stg, e.addr, e.stg);
                end
            end
        end else if (q[k].size() > 0 && q[k][0].cyc == cyc) begin
            e = q[k].pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing at cycle %0d: got no strobe, required addr=%0d", nm, cyc, e.addr);
        end
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            chk(0, "rd",     rd_en,    int'(rd_addr), int'(stage));
            chk(1, "tf",     tf_en,    int'(tf_addr), int'(stage));
            chk(2, "bypass", bypass_n, 0, 0);
            chk(3, "wr",     wr_en,    int'(wr_addr), int'(stage));
            chk(4, "done",   done,     0, 0);
            checks++;
            if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
                errors++;
                $display("FAIL busy at cycle %0d: got %b, required %b", cyc, busy, (cyc >= busy_lo && cyc <= busy_hi));
            end
        end
    end

    task automatic check_zero(input string tag);
        checks++;
        if ({busy, done, stage, rd_en, rd_addr, tf_en, tf_addr, bypass_n, wr_en, wr_addr} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got %b, required all zero", tag,
                     {busy, done, stage, rd_en, rd_addr, tf_en, tf_addr, bypass_n, wr_en, wr_addr});
        end
    endtask

    // Build the schedule from the rules: each stage issues G groups on non-held cycles,
    // then drains RD_LAT+3 cycles; done one cycle after the last drain cycle.
    task automatic run(input bit spam, input int abort_at);
        int  t0, c, g, done_c, holds;
        ev_t e;
        @(posedge Clk);
        #1;
        t0    = cyc;
        start = 1'b1;
        hold  = hp[0];
        c     = 1;
        holds = 0;
        for (int s = 0; s < S; s++) begin
            g = 0;
            while (g < G) begin
                if (c < HP_N && hp[c]) begin
                    holds++;
                end else begin
                    e = '{t0 + c, g, s};                        q[0].push_back(e);
                    e = '{t0 + c + 1, (g * (1 << s)) % G, s};   q[1].push_back(e);
                    if (s != S - 1) begin
                        e = '{t0 + c + RD_LAT + 2, 0, 0};       q[2].push_back(e);
                    end
                    e = '{t0 + c + RD_LAT + 3, g, s};           q[3].push_back(e);
                    g++;
                end
                c++;
            end
            c += RD_LAT + 3;
        end
        done_c  = c;
        e       = '{t0 + done_c, 0, 0};
        q[4].push_back(e);
        busy_lo = t0 + 1;
        busy_hi = t0 + done_c;

        for (int r = 1; r <= done_c + 3; r++) begin
            @(posedge Clk);
            #1;
            start = spam && (r < done_c - 1);
            hold  = (r < HP_N) ? hp[r] : 1'b0;
            if (abort_at != 0 && r == abort_at) begin
                for (int k = 0; k < 5; k++) q[k].delete();
                busy_hi = 0;
                #1;
                Reset_n = 1'b0;
                #1;
                check_zero("async reset");
            end
            if (abort_at != 0 && r == abort_at + 2) begin
                Reset_n = 1'b1;
            end
        end
        start = 1'b0;
        hold  = 1'b0;

        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL stream %0d leftover: got %0d pending events, required 0", k, q[k].size());
                q[k].delete();
            end
        end
`ifdef PE_SEQ_PERF_EN
        if (abort_at == 0) begin
            checks++;
            if (cycle_count != 32'(done_c)) begin
                errors++;
                $display("FAIL cycle_count: got %0d, required %0d", cycle_count, done_c);
            end
            checks++;
            if (hold_count != 32'(holds)) begin
                errors++;
                $display("FAIL hold_count: got %0d, required %0d", hold_count, holds);
            end
        end
`endif
    endtask

    task automatic clear_hp();
        for (int i = 0; i < HP_N; i++) hp[i] = 1'b0;
    endtask

    initial begin
        clear_hp();
        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset");
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        mon_en = 1'b1;

        // plain run: rd 0..3 per stage, done 25 cycles after start
        run(1'b0, 0);

        // hold for two cycles after group 1 issued: done moves to 27
        clear_hp();
        hp[3] = 1'b1;
        hp[4] = 1'b1;
        run(1'b0, 0);

        // start kept high while busy must not restart or add done pulses
        clear_hp();
        run(1'b1, 0);

        // random hold patterns, hold also toggling during drain
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < HP_N; i++) hp[i] = ($urandom_range(0, 3) == 0);
            run(n[0], 0);
        end

        // reset in the middle of stage 1, then a clean run
        clear_hp();
        run(1'b0, 12);
        run(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
